// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states
// and the datapath mux/ALU select codes.
package cpu_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: exactly one of the outputs is high for any op.
module mc_op_decode
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  output logic       is_r,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_illegal
);

  // Opcode match to one-hot class
  always_comb begin
    is_r       = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_R:    is_r       = 1'b1;
      OP_LW:   is_lw      = 1'b1;
      OP_SW:   is_sw      = 1'b1;
      OP_BEQ:  is_beq     = 1'b1;
      OP_J:    is_j       = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU control FSM: sequences one shared memory port and ALU through
// fetch/decode/execute/memory/writeback, and reports retirement and illegal ops.
module multi_cycle_controller
  import cpu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [STATE_W-1:0] state,
  output logic               retire,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             is_r_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_illegal_s;

  mc_op_decode u_op_decode (
    .op         (op),
    .is_r       (is_r_s),
    .is_lw      (is_lw_s),
    .is_sw      (is_sw_s),
    .is_beq     (is_beq_s),
    .is_j       (is_j_s),
    .is_illegal (is_illegal_s)
  );

  // State and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next state and control outputs; reset gating here makes outputs drop immediately
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    if (!rst_n) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_4;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMMSH;
          if (is_lw_s || is_sw_s) begin
            state_d = S_MEMADR;
          end else if (is_r_s) begin
            state_d = S_EXEC;
          end else if (is_beq_s) begin
            state_d = S_BRANCH;
          end else if (is_j_s) begin
            state_d = S_JUMP;
          end else begin
            illegal_op = is_illegal_s;
            state_d    = S_FETCH;
          end
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          // IR is stable here, so only LW/SW can reach this state
          if (is_lw_s) begin
            state_d = S_MEMRD;
          end else if (is_sw_s) begin
            state_d = S_MEMWR;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = mem_ready;
          state_d  = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Retire counter wraps silently modulo 2^CNT_W
  always_comb begin
    if (retire) begin
      instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instr_count_d = instr_count_q;
    end
  end

  assign state       = STATE_W'(state_q);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized scoreboard bench for multi_cycle_controller (32-bit and 4-bit counter instances).
module tb_multi_cycle_controller;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3,
                         ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6, ST_ALUWB = 4'd7,
                         ST_BRANCH = 4'd8, ST_JUMP = 4'd9;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_J = 6'b000010;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ret;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op;
  logic mem_ready;

  logic pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, m2r_a, irw_a, srca_a, rw_a, rd_a, ret_a, ill_a;
  logic [1:0] pcs_a, aop_a, srcb_a;
  logic [3:0] st_a;
  logic [31:0] cnt_a;
  logic pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, m2r_b, irw_b, srca_b, rw_b, rd_b, ret_b, ill_b;
  logic [1:0] pcs_b, aop_b, srcb_b;
  logic [3:0] st_b;
  logic [3:0] cnt_b;

  multi_cycle_controller #(.CNT_W(32), .STATE_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mrd_a), .MemWrite(mwr_a),
    .MemtoReg(m2r_a), .IRWrite(irw_a), .PCSource(pcs_a), .ALUOp(aop_a), .ALUSrcA(srca_a),
    .ALUSrcB(srcb_a), .RegWrite(rw_a), .RegDst(rd_a), .state(st_a), .retire(ret_a),
    .illegal_op(ill_a), .instr_count(cnt_a)
  );

  multi_cycle_controller #(.CNT_W(4), .STATE_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mrd_b), .MemWrite(mwr_b),
    .MemtoReg(m2r_b), .IRWrite(irw_b), .PCSource(pcs_b), .ALUOp(aop_b), .ALUSrcA(srca_b),
    .ALUSrcB(srcb_b), .RegWrite(rw_b), .RegDst(rd_b), .state(st_b), .retire(ret_b),
    .illegal_op(ill_b), .instr_count(cnt_b)
  );

  wire [15:0] ctrl_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, m2r_a, irw_a, pcs_a, aop_a,
                        srca_a, srcb_a, rw_a, rd_a};
  wire [15:0] ctrl_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, m2r_b, irw_b, pcs_b, aop_b,
                        srca_b, srcb_b, rw_b, rd_b};

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] model_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word expected in each state, straight from the per-state output list
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd} = 10'd0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (st)
      ST_FETCH:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE: srcb = 2'b11;
      ST_MEMADR: begin srca = 1'b1; srcb = 2'b10; end
      ST_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      ST_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      ST_EXEC:   begin srca = 1'b1; aop = 2'b10; end
      ST_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
      ST_BRANCH: begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      ST_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
      default:   pcs = 2'b00;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rw, rd};
  endfunction

  // One clock of stimulus plus the response the controller must show during it
  task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] opv,
                      input logic ret, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    op = opv;
    mem_ready = mr;
    e.st = st; e.ctrl = exp_ctrl(st, mr); e.ret = ret; e.ill = ill; e.cnt = model_cnt;
    q.push_back(e);
    if (ret) model_cnt = model_cnt + 32'd1;
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Whole instruction: wf fetch wait cycles, wm memory wait cycles
  task automatic run_instr(input logic [5:0] opv, input int wf, input int wm);
    for (int i = 0; i < wf; i++) step(ST_FETCH, 1'b0, rnd_op(), 1'b0, 1'b0);
    step(ST_FETCH, 1'b1, rnd_op(), 1'b0, 1'b0);
    case (opv)
      O_LW: begin
        step(ST_DECODE, rnd_bit(), opv, 1'b0, 1'b0);
        step(ST_MEMADR, rnd_bit(), opv, 1'b0, 1'b0);
        for (int i = 0; i < wm; i++) step(ST_MEMRD, 1'b0, opv, 1'b0, 1'b0);
        step(ST_MEMRD, 1'b1, opv, 1'b0, 1'b0);
        step(ST_MEMWB, rnd_bit(), opv, 1'b1, 1'b0);
      end
      O_SW: begin
        step(ST_DECODE, rnd_bit(), opv, 1'b0, 1'b0);
        step(ST_MEMADR, rnd_bit(), opv, 1'b0, 1'b0);
        for (int i = 0; i < wm; i++) step(ST_MEMWR, 1'b0, opv, 1'b0, 1'b0);
        step(ST_MEMWR, 1'b1, opv, 1'b1, 1'b0);
      end
      O_R: begin
        step(ST_DECODE, rnd_bit(), opv, 1'b0, 1'b0);
        step(ST_EXEC, rnd_bit(), opv, 1'b0, 1'b0);
        step(ST_ALUWB, rnd_bit(), opv, 1'b1, 1'b0);
      end
      O_BEQ: begin
        step(ST_DECODE, rnd_bit(), opv, 1'b0, 1'b0);
        step(ST_BRANCH, rnd_bit(), opv, 1'b1, 1'b0);
      end
      O_J: begin
        step(ST_DECODE, rnd_bit(), opv, 1'b0, 1'b0);
        step(ST_JUMP, rnd_bit(), opv, 1'b1, 1'b0);
      end
      default: step(ST_DECODE, rnd_bit(), opv, 1'b0, 1'b1);
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 5))
      0: o = O_R;
      1: o = O_LW;
      2: o = O_SW;
      3: o = O_BEQ;
      4: o = O_J;
      default: begin
        o = rnd_op();
        while (o == O_R || o == O_LW || o == O_SW || o == O_BEQ || o == O_J) o = rnd_op();
      end
    endcase
    return o;
  endfunction

  // Monitor: every out-of-reset cycle with a pending expectation is compared
  always @(negedge clk) begin
    if (rst_n === 1'b1 && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state_a", {28'd0, st_a}, {28'd0, e.st});
      chk("ctrl_a", {16'd0, ctrl_a}, {16'd0, e.ctrl});
      chk("retire_a", {31'd0, ret_a}, {31'd0, e.ret});
      chk("illegal_a", {31'd0, ill_a}, {31'd0, e.ill});
      chk("count_a", cnt_a, e.cnt);
      chk("state_b", {28'd0, st_b}, {28'd0, e.st});
      chk("ctrl_b", {16'd0, ctrl_b}, {16'd0, e.ctrl});
      chk("retire_b", {31'd0, ret_b}, {31'd0, e.ret});
      chk("count_b_wrap", {28'd0, cnt_b}, {28'd0, e.cnt[3:0]});
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {16'd0, ctrl_a}, 32'd0);
    chk({tag, "_mwr"}, {31'd0, mwr_a}, 32'd0);
    chk({tag, "_state"}, {28'd0, st_a}, 32'd0);
    chk({tag, "_count"}, cnt_a, 32'd0);
    chk({tag, "_count_b"}, {28'd0, cnt_b}, 32'd0);
    chk({tag, "_retire"}, {30'd0, ret_a, ill_a}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    op = 6'd0;
    mem_ready = 1'b0;
    #3;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed sequence: LW, stalled SW, R, BEQ, J, then an illegal opcode
    run_instr(O_LW, 0, 0);
    run_instr(O_SW, 0, 3);
    run_instr(O_R, 0, 0);
    run_instr(O_BEQ, 0, 0);
    run_instr(O_J, 0, 0);
    run_instr(6'b111111, 0, 0);

    for (int n = 0; n < 250; n++) begin
      run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Abort a stalled store with reset: MemWrite must drop without waiting for a clock
    run_instr(O_R, 0, 0);
    step(ST_FETCH, 1'b1, rnd_op(), 1'b0, 1'b0);
    step(ST_DECODE, 1'b0, O_SW, 1'b0, 1'b0);
    step(ST_MEMADR, 1'b0, O_SW, 1'b0, 1'b0);
    step(ST_MEMWR, 1'b0, O_SW, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("pre_abort_mwr", {31'd0, mwr_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    chk_reset_outputs("abort_hold");
    model_cnt = 32'd0;
    rst_n = 1'b1;

    for (int n = 0; n < 20; n++) begin
      run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
